pixel_loader: RTL

PIXEL_LOADER -- requirements
Module: pixel_loader

---
 rtl/snn_pkg.sv | 16 +
 rtl/pixel_loader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/snn_pkg.sv
// Shared SNN definitions: image geometry and pixel loader state encoding.
// Contents: NUM_PIXELS_DEFAULT, PIX_ADDR_W, BYTES_PER_IMG, loader_state_t.
// Used by pixel_loader and any consumer addressing the pixel RAM.
package snn_pkg;

  localparam int NUM_PIXELS_DEFAULT = 784;
  localparam int PIX_ADDR_W         = 10;
  localparam int BYTES_PER_IMG      = 98;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    UNPACK = 2'd1,
    FULL   = 2'd2
  } loader_state_t;

endpackage

// File: rtl/pixel_loader.sv
// Pixel loader: unpacks UART bytes LSB-first into a 1-bit pixel RAM and flags a full image.
// Latency: first RAM write 1 cycle after rx_rdy, 8 writes per byte; img_valid the cycle after the last write.
// Backpressure: none on the UART side; a byte arriving during UNPACK or FULL is dropped and sets sticky overrun.
//
// Ports: clk, rst (sync, active-high); rx_rdy/rx_data from UART; ram_we/ram_addr/ram_wdata to pixel RAM;
//        img_valid/img_done handshake with the SNN core; overrun sticky drop flag.
// Optional: define PIXEL_LOADER_TIMEOUT_EN to add an inter-byte watchdog that discards a stalled partial image.
module pixel_loader
  import snn_pkg::*;
#(
  parameter int NUM_PIXELS     = NUM_PIXELS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 130200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_rdy,
  input  logic [7:0]            rx_data,
  output logic                  ram_we,
  output logic [PIX_ADDR_W-1:0] ram_addr,
  output logic                  ram_wdata,
  output logic                  img_valid,
  input  logic                  img_done,
  output logic                  overrun
);

  localparam int          NUM_BYTES = NUM_PIXELS / 8;
  localparam logic [6:0]  LAST_CNT  = 7'(NUM_BYTES);

  // Elaboration-time guard on the parameters.
  if (NUM_PIXELS % 8 != 0 || NUM_BYTES > 127 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("pixel_loader: NUM_PIXELS must be a multiple of 8 (<=1016), TIMEOUT_CYCLES >= 1");
  end

  loader_state_t state, state_nxt;
  logic [7:0]    byte_q, byte_nxt;
  logic [6:0]    byte_cnt, byte_cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic          overrun_nxt;
  logic          wd_fire;

`ifdef PIXEL_LOADER_TIMEOUT_EN
  // Watchdog runs only while a partial image is waiting for its next byte.
  logic [31:0] wd_cnt, wd_cnt_nxt;

  always_comb begin
    wd_cnt_nxt = '0;
    wd_fire    = 1'b0;
    if (state == LOAD && byte_cnt != 7'd0 && !rx_rdy) begin
      if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) wd_fire = 1'b1;
      else                                   wd_cnt_nxt = wd_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_cnt <= '0;
    else     wd_cnt <= wd_cnt_nxt;
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    byte_nxt     = byte_q;
    byte_cnt_nxt = byte_cnt;
    bit_cnt_nxt  = bit_cnt;
    overrun_nxt  = overrun;
    case (state)
      LOAD: begin
        if (rx_rdy) begin
          byte_nxt    = rx_data;
          bit_cnt_nxt = 3'd0;
          state_nxt   = UNPACK;
        end else if (wd_fire) begin
          byte_cnt_nxt = 7'd0;
        end
      end
      UNPACK: begin
        if (rx_rdy) overrun_nxt = 1'b1;
        if (bit_cnt == 3'd7) begin
          bit_cnt_nxt  = 3'd0;
          byte_cnt_nxt = byte_cnt + 7'd1;
          state_nxt    = (byte_cnt + 7'd1 == LAST_CNT) ? FULL : LOAD;
        end else begin
          bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
      FULL: begin
        if (rx_rdy) overrun_nxt = 1'b1;
        if (img_done) begin
          byte_cnt_nxt = 7'd0;
          state_nxt    = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Outputs are registered from the next-state values so each UNPACK cycle
  // presents its own write, and the address holds between bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      byte_q    <= 8'd0;
      byte_cnt  <= 7'd0;
      bit_cnt   <= 3'd0;
      overrun   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 1'b0;
      img_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      byte_q    <= byte_nxt;
      byte_cnt  <= byte_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      overrun   <= overrun_nxt;
      ram_we    <= (state_nxt == UNPACK);
      img_valid <= (state_nxt == FULL);
      if (state_nxt == UNPACK) begin
        ram_addr  <= {byte_cnt_nxt, bit_cnt_nxt};
        ram_wdata <= byte_nxt[bit_cnt_nxt];
      end
    end
  end

endmodule
